// File: rtl/regfile_writeback_buffer.sv
// Write-side front end of the register file: merges ALU writebacks and load returns onto
// one registered write port, queueing colliding loads and offering forwarding lookups.
module regfile_writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_wsel,
    input  logic [DW-1:0]            alu_wdat,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_wsel,
    input  logic [DW-1:0]            ld_wdat,
    output logic                     ld_ready,
    output logic                     WEN,
    output logic [AW-1:0]            wsel,
    output logic [DW-1:0]            wdat,
    input  logic [AW-1:0]            rsel1,
    input  logic [AW-1:0]            rsel2,
    output logic                     fwd1_hit,
    output logic [DW-1:0]            fwd1_dat,
    output logic                     fwd2_hit,
    output logic [DW-1:0]            fwd2_dat,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Handshake: a load transfers on a cycle where ld_valid && ld_ready at posedge CLK;
    // ld_ready depends only on reset and physical occupancy, never on ld_valid.

    logic [AW-1:0]    q_sel [DEPTH];
    logic [DW-1:0]    q_dat [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic             out_wen;
    logic [AW-1:0]    out_sel;
    logic [DW-1:0]    out_dat;

    logic             alu_go;
    logic             keep;
    logic             first_found;
    logic [CW-1:0]    first_off;
    logic             pop;
    logic             bypass;
    logic             push;
    logic [CW-1:0]    free_n;
    logic [PW-1:0]    head_idx;
    logic [DEPTH-1:0] vld_next;

    assign ld_ready = nRST && (count != CW'(DEPTH));
    assign alu_go   = alu_valid && (alu_wsel != '0);
    // A same-cycle load to the ALU's register is older, so it is handshaken but dropped.
    assign keep     = ld_valid && ld_ready && (ld_wsel != '0) &&
                      !(alu_go && (ld_wsel == alu_wsel));

    always_comb begin
        first_found = 1'b0;
        first_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!first_found && (CW'(i) < count) && q_vld[head + PW'(i)]) begin
                first_found = 1'b1;
                first_off   = CW'(i);
            end
        end
    end

    assign pop      = !alu_go && first_found;
    assign bypass   = !alu_go && !first_found && keep;
    assign push     = keep && !bypass;
    assign head_idx = head + first_off[PW-1:0];
    // Invalidated slots ahead of the first live entry are reclaimed every cycle,
    // so a pop never spends a WEN cycle on a dead entry.
    assign free_n   = pop ? first_off + CW'(1) : (first_found ? first_off : count);

    always_comb begin
        vld_next = q_vld;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < free_n) vld_next[head + PW'(i)] = 1'b0;
        end
        if (alu_go) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (q_sel[j] == alu_wsel) vld_next[j] = 1'b0;
            end
        end
        if (push) vld_next[tail] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            q_vld   <= '0;
            out_wen <= 1'b0;
            out_sel <= '0;
            out_dat <= '0;
        end else begin
            head    <= head + free_n[PW-1:0];
            tail    <= tail + PW'(push);
            count   <= count - free_n + CW'(push);
            q_vld   <= vld_next;
            out_wen <= alu_go || pop || bypass;
            if (alu_go) begin
                out_sel <= alu_wsel;
                out_dat <= alu_wdat;
            end else if (pop) begin
                out_sel <= q_sel[head_idx];
                out_dat <= q_dat[head_idx];
            end else if (bypass) begin
                out_sel <= ld_wsel;
                out_dat <= ld_wdat;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_sel[tail] <= ld_wsel;
            q_dat[tail] <= ld_wdat;
        end
    end

    assign WEN     = out_wen;
    assign wsel    = out_sel;
    assign wdat    = out_dat;
    assign pending = CW'($countones(q_vld));

    // Scan oldest to youngest so the youngest live match overrides the output stage.
    always_comb begin
        fwd1_hit = out_wen && (out_sel == rsel1);
        fwd1_dat = fwd1_hit ? out_dat : '0;
        fwd2_hit = out_wen && (out_sel == rsel2);
        fwd2_dat = fwd2_hit ? out_dat : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && q_vld[head + PW'(i)]) begin
                if (q_sel[head + PW'(i)] == rsel1) begin
                    fwd1_hit = 1'b1;
                    fwd1_dat = q_dat[head + PW'(i)];
                end
                if (q_sel[head + PW'(i)] == rsel2) begin
                    fwd2_hit = 1'b1;
                    fwd2_dat = q_dat[head + PW'(i)];
                end
            end
        end
        if (rsel1 == '0) begin
            fwd1_hit = 1'b0;
            fwd1_dat = '0;
        end
        if (rsel2 == '0) begin
            fwd2_hit = 1'b0;
            fwd2_dat = '0;
        end
    end
endmodule
